// File: rtl/iob_wdog.sv
// iob_wdog: watchdog timer on the native iob bus with lockable control and a sticky expiry cause.
// Define IOB_WDOG_PREWARN_EN to add the wdog_irq_o pre-warning interrupt.
module iob_wdog #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 2,
  parameter int unsigned       RST_LEN = 16,
  parameter logic [DATA_W-1:0] KEY     = DATA_W'(32'h5A5AA5A5)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                wdog_rst_o
`ifdef IOB_WDOG_PREWARN_EN
  ,
  output logic                wdog_irq_o
`endif
);

  localparam int unsigned      BiteW    = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [BiteW-1:0] BiteLast = BiteW'(RST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StBite} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   load_q, load_d;
  logic [BiteW-1:0]    bite_cnt_q, bite_cnt_d;
  logic                lock_q, lock_d;
  logic                expired_q, expired_d;
  logic                badkey_q, badkey_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                wdog_rst_q, wdog_rst_d;

  logic wr, sel_ctrl, sel_load, sel_kick, sel_count;
  logic ctrl_wr, en_set, en_clr, kick_ok, kick_bad, bite_entry;

  assign wr        = valid_i && (|wstrb_i);
  assign sel_ctrl  = (address_i == ADDR_W'(0));
  assign sel_load  = (address_i == ADDR_W'(1));
  assign sel_kick  = (address_i == ADDR_W'(2));
  assign sel_count = (address_i == ADDR_W'(3));

  assign ctrl_wr    = wr && sel_ctrl && wstrb_i[0];
  assign en_set     = ctrl_wr && wdata_i[0] && (state_q == StIdle);
  assign en_clr     = ctrl_wr && !wdata_i[0] && !lock_q && (state_q == StRun);
  assign kick_ok    = wr && sel_kick && (state_q == StRun) && (wdata_i == KEY);
  assign kick_bad   = wr && sel_kick && (state_q == StRun) && (wdata_i != KEY);
  assign bite_entry = (state_q == StRun) && (state_d == StBite);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en_set) state_d = StRun;
      StRun: begin
        // A good kick beats expiry on the count==0 cycle
        if (en_clr) begin
          state_d = StIdle;
        end else if (!kick_ok && (count_q == '0)) begin
          state_d = StBite;
        end
      end
      StBite:  if (bite_cnt_q == BiteLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    load_d     = load_q;
    lock_d     = lock_q | (ctrl_wr & wdata_i[1]);
    expired_d  = expired_q & ~(ctrl_wr & wdata_i[2]);
    badkey_d   = badkey_q & ~(ctrl_wr & wdata_i[3]);
    bite_cnt_d = ((state_q == StBite) && (state_d == StBite)) ? bite_cnt_q + BiteW'(1) : '0;

    if (en_set || kick_ok) begin
      count_d = load_q;
    end else if ((state_q == StRun) && !en_clr && (count_q != '0)) begin
      count_d = count_q - DATA_W'(1);
    end

    if (wr && sel_load && !lock_q) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (wstrb_i[b]) load_d[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end

    if (bite_entry) expired_d = 1'b1;
    if (kick_bad)   badkey_d  = 1'b1;
  end

  always_comb begin
    ready_d    = valid_i;
    wdog_rst_d = (state_q == StBite);
    rdata_d    = '0;
    if (valid_i && !wr) begin
      if (sel_ctrl) begin
        rdata_d = {{(DATA_W-4){1'b0}}, badkey_q, expired_q, lock_q, state_q == StRun};
      end else if (sel_load) begin
        rdata_d = load_q;
      end else if (sel_count) begin
        rdata_d = count_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      load_q     <= '0;
      bite_cnt_q <= '0;
      lock_q     <= 1'b0;
      expired_q  <= 1'b0;
      badkey_q   <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      wdog_rst_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_q     <= load_d;
      bite_cnt_q <= bite_cnt_d;
      lock_q     <= lock_d;
      expired_q  <= expired_d;
      badkey_q   <= badkey_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      wdog_rst_q <= wdog_rst_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign ready_o    = ready_q;
  assign wdog_rst_o = wdog_rst_q;

`ifdef IOB_WDOG_PREWARN_EN
  logic irq_q, irq_d;

  // Evaluated on next-state values so the flag lines up with the COUNT it reports
  assign irq_d = (state_d == StRun) && !kick_ok && (count_d <= (load_q >> 2));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign wdog_irq_o = irq_q;
`endif

endmodule

// File: tb/tb_iob_wdog.sv
// Self-checking bench for iob_wdog: bus responses go through a scoreboard queue, reset pulse
// timing and lock/kick behaviour are checked cycle by cycle against hand-computed values.
module tb_iob_wdog;

  localparam logic [31:0] Key = 32'h5A5AA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        wdog_rst;
`ifdef IOB_WDOG_PREWARN_EN
  logic        wdog_irq;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] mon_exp;
  string       mon_tag;
  logic        seen_rst;

  iob_wdog #(
    .DATA_W (32),
    .ADDR_W (2),
    .RST_LEN(16),
    .KEY    (Key)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .address_i (address),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .rdata_o   (rdata),
    .ready_o   (ready),
    .wdog_rst_o(wdog_rst)
`ifdef IOB_WDOG_PREWARN_EN
    ,
    .wdog_irq_o(wdog_irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus request driven at a negedge; the expected response goes to the scoreboard.
  task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input string name);
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = s;
    exp_q.push_back(exp);
    tag_q.push_back(name);
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(a, d, 4'hF, 32'h0, "write_resp");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus(a, 32'h0, 4'h0, exp, name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wdog_rst", 32'(wdog_rst), 32'h0);
`ifdef IOB_WDOG_PREWARN_EN
    chk("rst_irq", 32'(wdog_irq), 32'h0);
`endif
    cyc(2);
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: ready=1 rdata=%h, required no response", rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        chk(mon_tag, rdata, mon_exp);
      end
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
  end

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    address = 2'd0;
    wdata   = 32'h0;
    wstrb   = 4'h0;
    cyc(3);
    rst = 1'b0;

    // Reset state and register access
    rd(0, 32'h0, "reset_ctrl");
    rd(1, 32'h0, "reset_load");
    rd(3, 32'h0, "reset_count");
    wr(1, 32'h0000_1234);
    rd(1, 32'h0000_1234, "load_full");
    bus(1, 32'hAABB_CCDD, 4'b0101, 32'h0, "write_resp");
    rd(1, 32'h00BB_12DD, "load_bytewise");
    wr(0, 32'h1);
    rd(0, 32'h1, "run_ctrl");
    rd(3, 32'h00BB_12DC, "run_count");
    rd(2, 32'h0, "kick_reads_0");
    pulse_rst();
    rd(0, 32'h0, "post_rst_ctrl");
    rd(1, 32'h0, "post_rst_load");
    rd(3, 32'h0, "post_rst_count");

    // Expiry: LOAD=10, pulse on cycles t+12..t+27
    wr(1, 32'd10);
    wr(0, 32'h1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("expiry_rst", 32'(wdog_rst), 32'(k >= 12 && k <= 27));
    end
    rd(0, 32'h4, "expiry_ctrl");
    rd(3, 32'h0, "expiry_count");
    wr(0, 32'h4);
    rd(0, 32'h0, "expired_w1c");

    // LOAD=0 bites two cycles after enable
    wr(1, 32'd0);
    wr(0, 32'h1);
    @(negedge clk);
    chk("load0_rst_k1", 32'(wdog_rst), 32'h0);
    @(negedge clk);
    chk("load0_rst_k2", 32'(wdog_rst), 32'h1);
    cyc(18);
    chk("load0_rst_end", 32'(wdog_rst), 32'h0);
    rd(0, 32'h4, "load0_ctrl");
    wr(0, 32'h4);

    // Periodic kicks, then a kick on the count==0 cycle
    seen_rst = 1'b0;
    wr(1, 32'd100);
    wr(0, 32'h1);
    for (int i = 0; i < 20; i++) begin
      repeat (49) begin
        @(negedge clk);
        if (wdog_rst) seen_rst = 1'b1;
      end
      wr(2, Key);
    end
    cyc(99);
    rd(3, 32'd1, "kick_count_pre0");
    wr(2, Key);
    rd(3, 32'd100, "kick_at0_reload");
    rd(0, 32'h1, "kick_at0_ctrl");
    wr(0, 32'h0);
    rd(3, 32'd98, "disable_count_held");
    rd(0, 32'h0, "disable_ctrl");
    chk("kick_no_bite", 32'(seen_rst), 32'h0);

    // Bad key: no reload, BADKEY set, bite at t+22
    wr(1, 32'd20);
    wr(0, 32'h1);
    wr(2, 32'h1234_5678);
    rd(0, 32'h9, "badkey_ctrl");
    rd(3, 32'd18, "badkey_count");
    for (int k = 4; k <= 24; k++) begin
      @(negedge clk);
      chk("badkey_rst", 32'(wdog_rst), 32'(k >= 22));
    end
    cyc(16);
    rd(0, 32'hC, "badkey_after_bite");
    wr(0, 32'h8);
    rd(0, 32'h4, "badkey_w1c");
    wr(0, 32'h4);
    rd(0, 32'h0, "badkey_clean");

    // Lock: disable and LOAD write ignored, bite at original timeout
    wr(1, 32'd30);
    wr(0, 32'h3);
    wr(0, 32'h0);
    wr(1, 32'd5);
    rd(0, 32'h3, "lock_ctrl");
    rd(1, 32'd30, "lock_load");
    for (int k = 5; k <= 34; k++) begin
      @(negedge clk);
      chk("lock_rst", 32'(wdog_rst), 32'(k >= 32));
    end
    cyc(16);
    rd(0, 32'h6, "lock_after_bite");
    wr(0, 32'h4);
    wr(0, 32'h0);
    rd(0, 32'h2, "lock_sticky");
    pulse_rst();
    rd(0, 32'h0, "lock_cleared_by_rst");

`ifdef IOB_WDOG_PREWARN_EN
    // Pre-warning: LOAD=40 raises irq at COUNT=10, a kick drops it
    wr(1, 32'd40);
    wr(0, 32'h1);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk("prewarn_irq", 32'(wdog_irq), 32'(k >= 30));
    end
    wr(2, Key);
    chk("prewarn_kick_drop", 32'(wdog_irq), 32'h0);
    wr(0, 32'h0);
`endif

    cyc(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_wdog.md
# iob_wdog

Watchdog timer peripheral on one slave port of the peripheral bus split, using the native iob request/response bus. Software loads a timeout, enables the dog and must kick it with a key before the countdown expires. On expiry the block drives a fixed-length reset pulse that the system ORs into the CPU reset, alongside the boot reset. A sticky cause flag survives the pulse so firmware can tell a watchdog restart from a cold boot.

## Interface
- DATA_W, 32, bus data width and counter width
- ADDR_W, 2, word address width (4 registers)
- RST_LEN, 16, wdog_rst pulse length in cycles (≥1)
- KEY, 32'h5A5AA5A5, kick key
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high, one clock domain (clk) only
- valid  in  1  request valid
- address  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes; all-zero = read
- rdata  out  DATA_W  read data
- ready  out  1  response, one cycle after valid
- wdog_rst  out  1  reset request to the system reset OR
- wdog_irq  out  1  pre-warning interrupt (only with IOB_WDOG_PREWARN_EN)

## Operation
- Registers (word address):
  - 0 CTRL, R/W. bit0 EN, bit1 LOCK (set-only), bit2 EXPIRED (W1C), bit3 BADKEY (W1C). Only byte 0 is writable.
  - 1 LOAD, R/W, bytewise per wstrb.
  - 2 KICK, W; reads 0.
  - 3 COUNT, RO.
- FSM states:
  - IDLE: count held.
    - Write EN=1 → count←LOAD, go RUN.
  - RUN: each cycle, count==0 → BITE; else count−1.
    - Write EN=0 (LOCK clear) → IDLE, count held.
  - BITE: wdog_rst=1 for RST_LEN cycles, then IDLE. On entry: EN←0, EXPIRED←1.
- KICK write with wdata==KEY in RUN: count←LOAD. Kick wins over expiry in the same cycle.
- KICK with any other value: BADKEY←1, no reload. In any other state, KICK is ignored.
- LOCK=1:
  - CTRL.EN clear is ignored.
  - LOAD writes are ignored.
  - LOCK itself cannot be cleared.
  - W1C bits still work.
  - LOCK clears only on rst.
- A LOAD write while in RUN takes effect at the next kick or enable.
- Timeout: enable write accepted at cycle t → wdog_rst first high at t+LOAD+2. LOAD=0 is legal.
- Bus accesses in BITE complete normally; EN writes are ignored until IDLE.
- Unused address bits and unused CTRL bits read 0.

## Timing
- All outputs and registers are 0 on rst, including count, state (IDLE) and EXPIRED.
  - rst is never generated internally; wdog_rst must not feed this block's own rst.
- Bus handshake:
  - valid sampled at t → ready=1 exactly at t+1 for one cycle, rdata valid at t+1.
  - Back-to-back requests are accepted every cycle.
  - rdata is 0 when ready=0.
- Register side effects are visible in reads issued on the following cycle.
- wdog_rst is registered: asserted the cycle after the FSM enters BITE, deasserted after RST_LEN cycles, glitch-free.
- rst asserted mid-pulse drops wdog_rst immediately (asynchronous).

## Configuration
- IOB_WDOG_PREWARN_EN defined:
  - Port wdog_irq exists.
  - wdog_irq=1 (registered) while in RUN with count ≤ LOAD>>2.
  - Cleared by a valid kick, disable, BITE or rst.
- IOB_WDOG_PREWARN_EN undefined: no wdog_irq port and no comparator logic; all other behaviour identical.

## Test plan
- Reset: rst pulse mid-traffic → all outputs 0; CTRL, LOAD, COUNT read 0.
- Expiry: LOAD=10, EN=1 at t, no kicks → wdog_rst high for cycles t+12..t+27 (RST_LEN=16); afterwards CTRL reads 0x4.
- Kick: LOAD=100, kick with KEY every 50 cycles for 1000 cycles → wdog_rst never asserts. Kick on the count==0 cycle → reload, no bite.
- Bad key: kick with 0x12345678 → BADKEY=1, count keeps falling, bite occurs. Write 0x8 to CTRL → BADKEY cleared.
- Lock: write CTRL=0x3, then CTRL=0x0 and LOAD=5 → EN stays 1, LOAD unchanged, bite at the original timeout.
- Prewarn (macro on): LOAD=40 → wdog_irq rises when COUNT=10; a kick drops it on the next cycle.
